// File: rtl/up_dwn_cmd_gen_if.sv
// rtl/up_dwn_cmd_gen_if.sv - button inputs and command output of up_dwn_cmd_gen
//   btn_up  : raw up button, asynchronous, active-high, may bounce
//   btn_dwn : raw down button, asynchronous, active-high, may bounce
//   up_dwn  : command to up_down_counter (00 hold, 01 up, 10 down, 11 clear)
interface up_dwn_cmd_gen_if;
    logic       btn_up;
    logic       btn_dwn;
    logic [1:0] up_dwn;

    modport master (output btn_up, output btn_dwn, input up_dwn);
    modport slave  (input btn_up, input btn_dwn, output up_dwn);
endinterface

// File: rtl/up_dwn_cmd_gen.sv
// rtl/up_dwn_cmd_gen.sv - push-button command source for up_down_counter
//   up_dwn_btn_chan : one button: 2-flop sync, debounce, press detect, auto-repeat
//     i_clk, i_rst_n : clock, asynchronous active-low reset
//     i_btn          : raw button
//     i_other_db     : debounced level of the other button (freezes repeat)
//     o_db           : debounced level
//     o_press        : one-cycle press event
//     o_repeat       : one-cycle auto-repeat event
//   up_dwn_cmd_gen  : top
//     clk, reset     : clock, asynchronous active-low reset
//     bus            : btn_up/btn_dwn in, registered up_dwn out

module up_dwn_btn_chan #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    input  logic i_other_db,
    output logic o_db,
    output logic o_press,
    output logic o_repeat
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic          r_db_q;
    logic [DW-1:0] r_dcnt;
    state_t        r_state;
    logic [RW-1:0] r_rcnt;

    state_t        w_state_nxt;
    logic [RW-1:0] w_rcnt_nxt;
    logic          w_press;
    logic          w_repeat;
    logic          w_freeze;

    // Synchronizer and debounce: a new level is accepted only after it has
    // differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_db_q  <= 1'b0;
            r_dcnt  <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            if (r_sync2 == r_db) begin
                r_dcnt <= '0;
            end else if (r_dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                r_db   <= r_sync2;
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + DW'(1);
            end
        end
    end

    assign w_press  = r_db & ~r_db_q;
    // Both buttons down means a clear was issued; hold the repeat timer so
    // the clear is not followed by stray up/down repeats.
    assign w_freeze = r_db & i_other_db;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    // Release is tested first so it wins over a repeat due in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_repeat    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_nxt = ST_DELAY;
                    w_rcnt_nxt  = '0;
                end
            end
            ST_DELAY: begin
                if (!r_db) begin
                    w_state_nxt = ST_IDLE;
                    w_rcnt_nxt  = '0;
                end else if (!w_freeze) begin
                    if (r_rcnt == RW'(REPEAT_DELAY - 1)) begin
                        w_repeat    = 1'b1;
                        w_rcnt_nxt  = '0;
                        w_state_nxt = ST_REPEAT;
                    end else begin
                        w_rcnt_nxt = r_rcnt + RW'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (!r_db) begin
                    w_state_nxt = ST_IDLE;
                    w_rcnt_nxt  = '0;
                end else if (!w_freeze) begin
                    if (r_rcnt == RW'(REPEAT_PERIOD - 1)) begin
                        w_repeat   = 1'b1;
                        w_rcnt_nxt = '0;
                    end else begin
                        w_rcnt_nxt = r_rcnt + RW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_rcnt_nxt  = '0;
            end
        endcase
    end

    assign o_db     = r_db;
    assign o_press  = w_press;
    assign o_repeat = w_repeat;
endmodule

module up_dwn_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic              clk,
    input  logic              reset,
    up_dwn_cmd_gen_if.slave   bus
);
    logic       w_db_up;
    logic       w_db_dn;
    logic       w_press_up;
    logic       w_press_dn;
    logic       w_rep_up;
    logic       w_rep_dn;
    logic [1:0] r_up_dwn;

    up_dwn_btn_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan_up (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_btn      (bus.btn_up),
        .i_other_db (w_db_dn),
        .o_db       (w_db_up),
        .o_press    (w_press_up),
        .o_repeat   (w_rep_up)
    );

    up_dwn_btn_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan_dn (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_btn      (bus.btn_dwn),
        .i_other_db (w_db_up),
        .o_db       (w_db_dn),
        .o_press    (w_press_dn),
        .o_repeat   (w_rep_dn)
    );

    // Bit 0 = up event, bit 1 = down event; both together encode clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_up_dwn <= 2'b00;
        end else begin
            r_up_dwn <= {w_press_dn | w_rep_dn, w_press_up | w_rep_up};
        end
    end

    assign bus.up_dwn = r_up_dwn;
endmodule
